// File: rtl/ode_mem_map_pkg.sv
// Shared RAM map, fixed-point format and FSM encoding for the ODE solver blocks.
// The fixed-point format is signed Q8.8, so unity is 0x0100.
package ode_mem_map_pkg;

    localparam int unsigned N_ADD          = 0;
    localparam int unsigned M_ADD          = 1;
    localparam int unsigned HTEMP_ADD      = 4;
    localparam int unsigned X_PROCESS_BASE = 6;
    localparam int unsigned X_INIT_BASE    = 56;
    localparam int unsigned A_BASE         = 156;
    localparam int unsigned B_BASE         = 2656;
    localparam int unsigned U_BASE         = 5156;

    localparam int unsigned MAX_N        = 50;
    localparam int unsigned FP_FRAC_BITS = 8;
    localparam logic [15:0] FP_ONE       = 16'h0100;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_NM,
        S_RD_H,
        S_A_ADDR,
        S_A_MAC,
        S_B_ADDR,
        S_B_MAC,
        S_X_ADDR,
        S_X_UPD,
        S_DONE,
        S_REARM,
        S_ERROR
    } euler_state_e;

endpackage

// File: rtl/add_sub_cla.sv
// 16-bit signed carry-lookahead adder/subtractor; invalid flags two's-complement overflow.
module add_sub_cla (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        sub_i,
    output logic [15:0] sum_o,
    output logic        invalid_o
);
    logic [15:0] b_eff;
    logic [15:0] gen;
    logic [15:0] prop;
    logic [16:0] carry;

    assign b_eff = b_i ^ {16{sub_i}};
    assign gen   = a_i & b_eff;
    assign prop  = a_i ^ b_eff;

    // NOTE: every bit of carry is assigned on every pass, so no latch is inferred.
    always_comb begin
        carry    = '0;
        carry[0] = sub_i;
        for (int i = 0; i < 16; i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end
    end

    assign sum_o     = prop ^ carry[15:0];
    assign invalid_o = carry[16] ^ carry[15];

endmodule

// File: rtl/euler_mac.sv
// Accumulator datapath: acc += a*b in accumulate mode, x + h*acc in update mode.
// A single fault flag merges multiplier overflow and adder overflow.
module euler_mac (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        acc_en_i,
    input  logic        upd_i,
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic [15:0] h_i,
    output logic [15:0] result_o,
    output logic        flag_o
);
    logic [15:0] acc_q;
    logic [15:0] mul_a, mul_b, product, addend;
    logic        mult_overflow, add_invalid;

    // In update mode a_i carries x_init[i] straight from the RAM port.
    assign mul_a  = upd_i ? h_i   : a_i;
    assign mul_b  = upd_i ? acc_q : b_i;
    assign addend = upd_i ? a_i   : acc_q;

    multiplier_16bit u_mul (
        .a_i             (mul_a),
        .b_i             (mul_b),
        .product_o       (product),
        .mult_overflow_o (mult_overflow)
    );

    add_sub_cla u_add (
        .a_i       (addend),
        .b_i       (product),
        .sub_i     (1'b0),
        .sum_o     (result_o),
        .invalid_o (add_invalid)
    );

    assign flag_o = mult_overflow | add_invalid;

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else if (clear_i) begin
            acc_q <= '0;
        end else if (acc_en_i) begin
            acc_q <= result_o;
        end
    end

endmodule

// File: rtl/multiplier_16bit.sv
// Signed Q8.8 multiplier: full product rescaled by the fraction width, flagged when it leaves 16 bits.
module multiplier_16bit
    import ode_mem_map_pkg::*;
(
    input  logic signed [15:0] a_i,
    input  logic signed [15:0] b_i,
    output logic        [15:0] product_o,
    output logic               mult_overflow_o
);
    logic signed [31:0] full;
    logic signed [31:0] scaled;

    assign full            = a_i * b_i;
    assign scaled          = full >>> FP_FRAC_BITS;
    assign product_o       = scaled[15:0];
    assign mult_overflow_o = scaled[31:15] != {17{scaled[15]}};

endmodule

// File: rtl/euler_step_engine.sv
// One explicit Euler step over the RAM-resident state vector:
// x_process[i] = x_init[i] + h*(A[i]*x_init + B[i]*U), one write per row.
module euler_step_engine
    import ode_mem_map_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 13,
    parameter int DATA_WIDTH    = 64
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     Euler_Enable,
    output logic                     Euler_End,
    output logic                     Euler_Error,
    input  logic [DATA_WIDTH-1:0]    RAM_Data_RD_A,
    input  logic [DATA_WIDTH-1:0]    RAM_Data_RD_B,
    output logic [ADDRESS_WIDTH-1:0] RAM_Address_RD_A,
    output logic [ADDRESS_WIDTH-1:0] RAM_Address_RD_B,
    output logic [DATA_WIDTH-1:0]    RAM_Data_WR,
    output logic [ADDRESS_WIDTH-1:0] RAM_Address_WR,
    output logic                     Euler_Memory_WR_Enable
);
    localparam int AW = ADDRESS_WIDTH;

    euler_state_e  state_q;
    logic [AW-1:0] n_q, m_q, i_q, j_q, k_q;
    logic [AW-1:0] rd_a_q, rd_b_q;
    logic [15:0]   h_q;
    logic          end_q, err_q;

    logic [15:0]   mac_result;
    logic          mac_flag, in_mac, in_upd, wr_en;
    logic          last_i, last_j, last_k;

    assign in_mac = (state_q == S_A_MAC) || (state_q == S_B_MAC);
    assign in_upd = state_q == S_X_UPD;
    assign wr_en  = in_upd && !mac_flag;
    assign last_i = i_q == n_q - AW'(1);
    assign last_j = j_q == n_q - AW'(1);
    assign last_k = k_q == m_q - AW'(1);

    euler_mac u_mac (
        .clk_i    (CLK),
        .rst_i    (RST),
        .clear_i  ((state_q == S_RD_H) || in_upd),
        .acc_en_i (in_mac),
        .upd_i    (in_upd),
        .a_i      (RAM_Data_RD_A[15:0]),
        .b_i      (RAM_Data_RD_B[15:0]),
        .h_i      (h_q),
        .result_o (mac_result),
        .flag_o   (mac_flag)
    );

    // The write strobe must drop in the same cycle a fault is seen, so it stays combinational.
    assign Euler_Memory_WR_Enable = wr_en;
    assign RAM_Address_WR   = wr_en ? AW'(X_PROCESS_BASE) + i_q : '0;
    assign RAM_Data_WR      = wr_en ? {{(DATA_WIDTH-16){mac_result[15]}}, mac_result} : '0;
    assign RAM_Address_RD_A = rd_a_q;
    assign RAM_Address_RD_B = rd_b_q;
    assign Euler_End        = end_q;
    assign Euler_Error      = err_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            m_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            h_q     <= '0;
            end_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            end_q <= 1'b0;
            case (state_q)
                S_IDLE: if (Euler_Enable) begin
                    rd_a_q  <= AW'(N_ADD);
                    rd_b_q  <= AW'(M_ADD);
                    err_q   <= 1'b0;
                    state_q <= S_RD_NM;
                end
                S_RD_NM: begin
                    n_q <= RAM_Data_RD_A[AW-1:0];
                    m_q <= RAM_Data_RD_B[AW-1:0];
                    if (RAM_Data_RD_A > DATA_WIDTH'(MAX_N) || RAM_Data_RD_B > DATA_WIDTH'(MAX_N)) begin
                        state_q <= S_ERROR;
                    end else begin
                        rd_a_q  <= AW'(HTEMP_ADD);
                        state_q <= S_RD_H;
                    end
                end
                S_RD_H: begin
                    h_q <= RAM_Data_RD_A[15:0];
                    i_q <= '0;
                    j_q <= '0;
                    if (n_q == '0) begin
                        end_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_A_ADDR;
                    end
                end
                S_A_ADDR: begin
                    rd_a_q  <= AW'(A_BASE) + i_q * n_q + j_q;
                    rd_b_q  <= AW'(X_INIT_BASE) + j_q;
                    state_q <= S_A_MAC;
                end
                S_A_MAC: begin
                    if (mac_flag) begin
                        state_q <= S_ERROR;
                    end else if (!last_j) begin
                        j_q     <= j_q + AW'(1);
                        state_q <= S_A_ADDR;
                    end else if (m_q != '0) begin
                        k_q     <= '0;
                        state_q <= S_B_ADDR;
                    end else begin
                        state_q <= S_X_ADDR;
                    end
                end
                S_B_ADDR: begin
                    rd_a_q  <= AW'(B_BASE) + i_q * m_q + k_q;
                    rd_b_q  <= AW'(U_BASE) + k_q;
                    state_q <= S_B_MAC;
                end
                S_B_MAC: begin
                    if (mac_flag) begin
                        state_q <= S_ERROR;
                    end else if (!last_k) begin
                        k_q     <= k_q + AW'(1);
                        state_q <= S_B_ADDR;
                    end else begin
                        state_q <= S_X_ADDR;
                    end
                end
                S_X_ADDR: begin
                    rd_a_q  <= AW'(X_INIT_BASE) + i_q;
                    state_q <= S_X_UPD;
                end
                S_X_UPD: begin
                    if (mac_flag) begin
                        state_q <= S_ERROR;
                    end else if (!last_i) begin
                        i_q     <= i_q + AW'(1);
                        j_q     <= '0;
                        state_q <= S_A_ADDR;
                    end else begin
                        end_q   <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    rd_a_q  <= '0;
                    rd_b_q  <= '0;
                    state_q <= S_REARM;
                end
                S_REARM: if (!Euler_Enable) state_q <= S_IDLE;
                S_ERROR: begin
                    err_q   <= 1'b1;
                    end_q   <= 1'b1;
                    state_q <= S_DONE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_euler_step_engine.sv
// Directed and randomized checks of euler_step_engine against a plain-arithmetic Euler model.
module tb_euler_step_engine;
    import ode_mem_map_pkg::*;

    localparam int AW = 13;
    localparam int DW = 64;
    localparam longint FP_MAX = 32767;
    localparam longint FP_MIN = -32768;

    logic          CLK = 1'b0;
    logic          RST;
    logic          Euler_Enable;
    logic          Euler_End, Euler_Error, Euler_Memory_WR_Enable;
    logic [DW-1:0] RAM_Data_RD_A, RAM_Data_RD_B, RAM_Data_WR;
    logic [AW-1:0] RAM_Address_RD_A, RAM_Address_RD_B, RAM_Address_WR;

    logic [DW-1:0] mem [0:8191];
    logic [AW-1:0] wr_a [$];
    logic [DW-1:0] wr_d [$];
    logic [AW-1:0] exp_a [$];
    logic [DW-1:0] exp_d [$];
    int            exp_end;
    bit            exp_err;
    int            n_checks = 0;
    int            n_pass   = 0;

    euler_step_engine #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK                    (CLK),
        .RST                    (RST),
        .Euler_Enable           (Euler_Enable),
        .Euler_End              (Euler_End),
        .Euler_Error            (Euler_Error),
        .RAM_Data_RD_A          (RAM_Data_RD_A),
        .RAM_Data_RD_B          (RAM_Data_RD_B),
        .RAM_Address_RD_A       (RAM_Address_RD_A),
        .RAM_Address_RD_B       (RAM_Address_RD_B),
        .RAM_Data_WR            (RAM_Data_WR),
        .RAM_Address_WR         (RAM_Address_WR),
        .Euler_Memory_WR_Enable (Euler_Memory_WR_Enable)
    );

    always #5 CLK = ~CLK;

    assign RAM_Data_RD_A = mem[RAM_Address_RD_A];
    assign RAM_Data_RD_B = mem[RAM_Address_RD_B];

    // Writes land in x_process, which the engine never reads back, so a log is enough.
    always @(negedge CLK) begin
        if (Euler_Memory_WR_Enable === 1'b1) begin
            wr_a.push_back(RAM_Address_WR);
            wr_d.push_back(RAM_Data_WR);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic void fmul(input logic [15:0] a, input logic [15:0] b,
                                 output logic [15:0] r, output bit ov);
        longint p;
        p  = longint'($signed(a)) * longint'($signed(b));
        p  = p >>> 8;
        ov = (p > FP_MAX) || (p < FP_MIN);
        r  = p[15:0];
    endfunction

    function automatic void fadd(input logic [15:0] a, input logic [15:0] b,
                                 output logic [15:0] r, output bit ov);
        longint s;
        s  = longint'($signed(a)) + longint'($signed(b));
        ov = (s > FP_MAX) || (s < FP_MIN);
        r  = s[15:0];
    endfunction

    // Expected writes, error flag and End cycle, counting two cycles per MAC term
    // and two per row update after the three-cycle header.
    task automatic model();
        logic [63:0] nv, mv;
        logic [15:0] h, acc, p, s;
        bit          ov1, ov2;
        int          n, m, t;
        nv = mem[N_ADD];
        mv = mem[M_ADD];
        exp_a.delete();
        exp_d.delete();
        exp_err = 1'b0;
        if (nv > 64'd50 || mv > 64'd50) begin
            exp_err = 1'b1;
            exp_end = 3;
            return;
        end
        n = int'(nv);
        m = int'(mv);
        h = mem[HTEMP_ADD][15:0];
        t = 2;
        for (int i = 0; i < n; i++) begin
            acc = '0;
            for (int j = 0; j < n; j++) begin
                t += 2;
                fmul(mem[156 + i*n + j][15:0], mem[56 + j][15:0], p, ov1);
                fadd(acc, p, s, ov2);
                acc = s;
                if (ov1 || ov2) begin exp_err = 1'b1; exp_end = t + 2; return; end
            end
            for (int k = 0; k < m; k++) begin
                t += 2;
                fmul(mem[2656 + i*m + k][15:0], mem[5156 + k][15:0], p, ov1);
                fadd(acc, p, s, ov2);
                acc = s;
                if (ov1 || ov2) begin exp_err = 1'b1; exp_end = t + 2; return; end
            end
            t += 2;
            fmul(h, acc, p, ov1);
            fadd(mem[56 + i][15:0], p, s, ov2);
            if (ov1 || ov2) begin exp_err = 1'b1; exp_end = t + 2; return; end
            exp_a.push_back(AW'(6 + i));
            exp_d.push_back({{48{s[15]}}, s});
        end
        exp_end = t + 1;
    endtask

    task automatic clear_mem();
        for (int a = 0; a < 8192; a++) mem[a] = '0;
    endtask

    task automatic put(input int a, input logic [15:0] v, input bit garbage);
        logic [63:0] g;
        g       = garbage ? {$urandom, $urandom} : {{48{v[15]}}, v};
        g[15:0] = v;
        mem[a]  = g;
    endtask

    function automatic logic [15:0] rand16(input bit big);
        if (big) return 16'($urandom_range(0, 65535));
        return 16'($urandom_range(0, 1023) - 512);
    endfunction

    // Edge 0 is the first edge that sees Euler_Enable; End is sampled before edge e.
    task automatic run_engine(input bit drop, output int end_edge);
        end_edge = -1;
        @(negedge CLK);
        Euler_Enable = 1'b1;
        @(posedge CLK);
        for (int e = 1; e <= 5000; e++) begin
            @(negedge CLK);
            if (Euler_End === 1'b1) begin
                end_edge = e;
                break;
            end
        end
        if (drop) begin
            Euler_Enable = 1'b0;
            @(negedge CLK);
            if (end_edge > 0) check("end_one_cycle", 64'(Euler_End), 64'd0);
            @(negedge CLK);
        end
    endtask

    task automatic do_run(input string tag, output int e);
        model();
        wr_a.delete();
        wr_d.delete();
        run_engine(1'b1, e);
        check({tag, " end_cycle"}, 64'(e), 64'(exp_end));
        check({tag, " error"}, 64'(Euler_Error), 64'(exp_err));
        check({tag, " n_writes"}, 64'(wr_a.size()), 64'(exp_a.size()));
        for (int w = 0; w < exp_a.size() && w < wr_a.size(); w++) begin
            check($sformatf("%s wr%0d addr", tag, w), 64'(wr_a[w]), 64'(exp_a[w]));
            check($sformatf("%s wr%0d data", tag, w), wr_d[w], exp_d[w]);
        end
    endtask

    task automatic setup_unit();
        clear_mem();
        mem[N_ADD] = 64'd1;
        mem[M_ADD] = 64'd0;
        put(HTEMP_ADD, FP_ONE, 1'b0);
        put(A_BASE, FP_ONE, 1'b0);
        put(X_INIT_BASE, 16'h0200, 1'b0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " end"},   64'(Euler_End), 64'd0);
        check({tag, " wr_en"}, 64'(Euler_Memory_WR_Enable), 64'd0);
        check({tag, " rd_a"},  64'(RAM_Address_RD_A), 64'd0);
        check({tag, " rd_b"},  64'(RAM_Address_RD_B), 64'd0);
        check({tag, " wr_ad"}, 64'(RAM_Address_WR), 64'd0);
        check({tag, " wr_d"},  RAM_Data_WR, 64'd0);
        check({tag, " err"},   64'(Euler_Error), 64'd0);
    endtask

    initial begin
        int e;
        int ends;
        clear_mem();
        Euler_Enable = 1'b0;
        RST = 1'b0;
        #1 RST = 1'b1;
        #1 check_outputs_zero("reset");
        repeat (2) @(negedge CLK);
        RST = 1'b0;

        // h=1, A=1, x=2 -> 2 + 1*(1*2) = 4.
        setup_unit();
        do_run("unit", e);
        check("unit end=7", 64'(e), 64'd7);
        check("unit addr6", 64'(wr_a[0]), 64'd6);
        check("unit data4", wr_d[0], 64'h400);

        clear_mem();
        mem[N_ADD] = 64'd2;
        mem[M_ADD] = 64'd1;
        put(HTEMP_ADD, FP_ONE, 1'b0);
        put(B_BASE, FP_ONE, 1'b0);
        put(U_BASE, FP_ONE, 1'b0);
        put(X_INIT_BASE + 1, FP_ONE, 1'b0);
        do_run("nm21", e);
        check("nm21 end=19", 64'(e), 64'd19);
        check("nm21 row0", wr_d[0], 64'h100);
        check("nm21 row1", wr_d[1], 64'h100);
        check("nm21 addr7", 64'(wr_a[1]), 64'd7);

        clear_mem();
        do_run("n0", e);
        check("n0 end=3", 64'(e), 64'd3);
        check("n0 no write", 64'(wr_a.size()), 64'd0);

        clear_mem();
        mem[N_ADD] = 64'd51;
        do_run("n51", e);
        check("n51 error", 64'(Euler_Error), 64'd1);
        check("n51 end=3", 64'(e), 64'd3);
        check("n51 no write", 64'(wr_a.size()), 64'd0);

        // Row 1 multiplies 0x7FFF by 0x7FFF and must overflow after row 0 is written.
        clear_mem();
        mem[N_ADD] = 64'd2;
        put(HTEMP_ADD, FP_ONE, 1'b0);
        put(A_BASE + 2, 16'h7FFF, 1'b0);
        put(X_INIT_BASE, 16'h7FFF, 1'b0);
        do_run("ovf", e);
        check("ovf error", 64'(Euler_Error), 64'd1);
        check("ovf end=12", 64'(e), 64'd12);
        check("ovf one write", 64'(wr_a.size()), 64'd1);
        check("ovf row0", wr_d[0], 64'h7FFF);

        setup_unit();
        do_run("err_clear", e);
        check("err cleared", 64'(Euler_Error), 64'd0);

        // Reset while the first A_MAC is in progress.
        setup_unit();
        wr_a.delete();
        @(negedge CLK);
        Euler_Enable = 1'b1;
        repeat (4) @(posedge CLK);
        #1 check("mid A_MAC rd_a", 64'(RAM_Address_RD_A), 64'(A_BASE));
        RST = 1'b1;
        Euler_Enable = 1'b0;
        #1 check_outputs_zero("async_rst");
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst no write", 64'(wr_a.size()), 64'd0);
        do_run("after_rst", e);

        // Enable held through REARM must not restart until it drops.
        setup_unit();
        wr_a.delete();
        run_engine(1'b0, e);
        check("hold end=7", 64'(e), 64'd7);
        ends = 0;
        repeat (20) begin
            @(negedge CLK);
            if (Euler_End === 1'b1) ends++;
        end
        check("hold no restart", 64'(ends), 64'd0);
        check("hold one write", 64'(wr_a.size()), 64'd1);
        Euler_Enable = 1'b0;
        @(negedge CLK);
        run_engine(1'b1, e);
        check("rerun end=7", 64'(e), 64'd7);
        check("rerun writes", 64'(wr_a.size()), 64'd2);

        for (int it = 0; it < 8; it++) begin
            int n, m;
            bit big;
            clear_mem();
            n   = $urandom_range(1, 4);
            m   = $urandom_range(0, 3);
            big = (it % 3 == 2);
            mem[N_ADD] = 64'(n);
            mem[M_ADD] = 64'(m);
            put(HTEMP_ADD, 16'($urandom_range(64, 384)), 1'b1);
            for (int i = 0; i < n; i++) begin
                for (int j = 0; j < n; j++) put(156 + i*n + j, rand16(big), 1'b1);
                for (int k = 0; k < m; k++) put(2656 + i*m + k, rand16(big), 1'b1);
            end
            for (int j = 0; j < n; j++) put(56 + j, rand16(1'b0), 1'b1);
            for (int k = 0; k < m; k++) put(5156 + k, rand16(1'b0), 1'b1);
            do_run($sformatf("rnd%0d", it), e);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/euler_step_engine.md
# euler_step_engine

Responder end of the Euler handshake driven by the step-size controller. On `Euler_Enable` it performs one explicit Euler step over the state vector held in the shared 64-bit RAM: x_process[i] = x_init[i] + h·(Σj A[i][j]·x_init[j] + Σk B[i][k]·U[k]). It then pulses `Euler_End`. It sits beside the step controller on the RAM coordinator's read ports A and B and its write port.

## Interface
- `ADDRESS_WIDTH`, 13, RAM address width.
- `DATA_WIDTH`, 64, RAM word width. Arithmetic uses bits [15:0].
- `RST` in 1: asynchronous, active-high reset.
- `CLK` in 1: single clock; all state updates on the rising edge.
- `Euler_Enable` in 1: start request, level; held by the initiator until it sees `Euler_End`.
- `Euler_End` out 1: one-cycle completion pulse.
- `Euler_Error` out 1: sticky overflow/range flag; cleared on the next accepted start.
- `RAM_Data_RD_A`, `RAM_Data_RD_B` in DATA_WIDTH: read data.
- `RAM_Address_RD_A`, `RAM_Address_RD_B` out ADDRESS_WIDTH: registered read addresses.
- `RAM_Data_WR` out DATA_WIDTH: write data. It is the 16-bit result sign-extended to 64 bits.
- `RAM_Address_WR` out ADDRESS_WIDTH: write address.
- `Euler_Memory_WR_Enable` out 1: write strobe. The RAM writes on the edge where it is high.

## Operation
- RAM reads are asynchronous. Data for an address registered at edge k is sampled at edge k+1.
- Memory map:
  - N @0, M @1, htemp @4.
  - x_process base 6, x_init base 56.
  - A base 156, row-major N×N.
  - B base 2656, row-major N×M.
  - U base 5156.
- States and transitions:
  - IDLE: all outputs 0. `Euler_Enable`=1 → RD_NM, with RD_A=0 and RD_B=1. Clear `Euler_Error`.
  - RD_NM: latch N, M (full 64 bits). If N>50 or M>50 → ERROR. Otherwise RD_A=4 → RD_H.
  - RD_H: latch h=RD_A[15:0]; i=0. N=0 → DONE, else → A_ADDR with acc=0, j=0.
  - A_ADDR: RD_A=156+i·N+j, RD_B=56+j → A_MAC.
  - A_MAC: acc += RD_A·RD_B. j<N−1 → A_ADDR with j+1. Otherwise → B_ADDR if M>0 (k=0), else X_ADDR.
  - B_ADDR: RD_A=2656+i·M+k, RD_B=5156+k → B_MAC.
  - B_MAC: acc += RD_A·RD_B. k<M−1 → B_ADDR with k+1, else → X_ADDR.
  - X_ADDR: RD_A=56+i → X_UPD.
  - X_UPD: result = RD_A[15:0] + h·acc. Drive WR_Enable=1, address 6+i, data sext(result). Then i<N−1 → A_ADDR (acc=0, j=0), else → DONE.
  - DONE: `Euler_End`=1 for one cycle → REARM.
  - REARM: wait for `Euler_Enable`=0 → IDLE. This prevents a double run while the initiator drops enable.
  - ERROR: set `Euler_Error`, write nothing → DONE.
- Arithmetic:
  - 16-bit signed, in the native fixed-point format of `multiplier_16bit`.
  - Additions use `add_sub_cla`.
  - Any `mult_overflow` or adder `invalid` in A_MAC, B_MAC or X_UPD → ERROR instead of the state's normal action.
  - Rows already written stay written.
- Index arithmetic (i·N+j, i·M+k) uses 13-bit unsigned values. It cannot wrap when N and M are ≤50.
- `Euler_Memory_WR_Enable` is high only in X_UPD cycles.

## Timing
- Reset: all outputs 0, state IDLE. Reset mid-operation aborts immediately and no further writes occur.
- Latency: with the enable-sampling edge as edge 0, `Euler_End` is high in cycle 3 + N·(2N+2M+2).
- `Euler_Enable` falling mid-run is ignored; the run completes.
- `Euler_Enable` still high after REARM completes would restart a run. The initiator must drop it on the edge where it samples `Euler_End`.
- One write per row, in the last cycle of the row.

## Structure
- Package `ode_mem_map_pkg`:
  - Address constants: N_ADD, M_ADD, HTEMP_ADD, X_PROCESS_BASE, X_INIT_BASE, A_BASE, B_BASE, U_BASE.
  - MAX_N=50.
  - FP_ONE, the multiplier's unity code.
  - The state enum.
- Sub-module `euler_mac`: wraps one `multiplier_16bit` and one `add_sub_cla`. It provides accumulate, clear and the h·acc+x update, and ORs their overflow and invalid outputs into one flag.

## Test plan
- N=1, M=0, h=FP_ONE, A[0][0]=FP_ONE, x_init[0]=2·FP_ONE:
  - single write of 4·FP_ONE at address 6;
  - `Euler_End` in cycle 7;
  - `Euler_Error`=0.
- N=2, M=1, U[0]=FP_ONE, B=[FP_ONE, 0], A=0, h=FP_ONE, x_init=[0, FP_ONE]:
  - writes FP_ONE @6 then FP_ONE @7;
  - `Euler_End` in cycle 3+2·8=19.
- N=0: no write; `Euler_End` in cycle 3.
- N=51: `Euler_Error`=1 and no write; `Euler_End` pulses within 3 cycles.
- Operands forcing `mult_overflow` in row 1 of N=2:
  - row 0 written;
  - `Euler_Error`=1 and `Euler_End` pulses;
  - no write @7.
- `RST` asserted mid-A_MAC:
  - all outputs 0 asynchronously;
  - later enable reruns from IDLE with correct results.
- `Euler_Enable` held high through REARM: a second run starts only after enable passes through 0.
